// File: rtl/graphics_pkg.sv
// Shared graphics definitions: FP32 field constants, the vertex reader state
// encoding, default viewport size, result RAM depth and a saturation helper.
package graphics_pkg;

  localparam int EXP_BIAS      = 127;
  localparam int MANT_W        = 23;
  localparam int DEF_SCREEN_W  = 640;
  localparam int DEF_SCREEN_H  = 480;
  localparam int RESULT_DEPTH  = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_CONVERT,
    S_EMIT
  } state_t;

  // Clamp an 18-bit signed pixel coordinate into the 16-bit output range.
  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)  return 16'sh7FFF;
    if (v < -18'sd32768) return 16'sh8000;
    return $signed(v[15:0]);
  endfunction

endpackage

// File: rtl/fp32_to_fixed.sv
// Combinational IEEE-754 single to saturated 16-bit signed integer, scaled by
// 2^SCALE_SHIFT. Denormals flush to zero; Inf/NaN and out-of-range magnitudes
// saturate and raise ovf.
module fp32_to_fixed
  import graphics_pkg::*;
#(
  parameter int SCALE_SHIFT = 8
) (
  input  logic [31:0]        f,
  output logic signed [15:0] val,
  output logic               ovf
);

  logic        sgn;
  logic [7:0]  ex;
  logic [22:0] man;
  int          sh;
  logic [31:0] mag;

  assign sgn = f[31];
  assign ex  = f[30:23];
  assign man = f[22:0];

  // The hidden-one mantissa is already >= 2^23, so any non-negative shift
  // overflows 16 bits; only right shifts ever produce an in-range magnitude.
  always_comb begin
    sh  = int'(ex) - EXP_BIAS - MANT_W + SCALE_SHIFT;
    mag = '0;
    val = '0;
    ovf = 1'b0;
    if (sh < 0) mag = {8'd0, 1'b1, man} >> (-sh);
    if (ex == 8'd0) begin
      val = '0;
    end else if (ex == 8'hFF || sh >= 0 || mag > 32'd32767) begin
      ovf = 1'b1;
      val = sgn ? 16'sh8000 : 16'sh7FFF;
    end else begin
      val = sgn ? -$signed(mag[15:0]) : $signed(mag[15:0]);
    end
  end

endmodule

// File: rtl/mvp_vertex_reader.sv
// Drains x,y,z float triples from the MVP result RAM, maps x,y to viewport
// pixels, flags clipped vertices and hands them out over valid/ready.
// Build option: CLIP_REJECT_EN drops clipped vertices from the stream; a
// one-vertex hold is used so v_last can land on the last surviving vertex.
module mvp_vertex_reader
  import graphics_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int SCALE_SHIFT = 8,
  parameter int RD_LAT      = 2,
  parameter int MAX_VERTS   = RESULT_DEPTH / 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] count,
  output logic        done,
  output logic [31:0] result_addr,
  input  logic [31:0] result_data,
  output logic        v_valid,
  input  logic        v_ready,
  output logic [15:0] v_x,
  output logic [15:0] v_y,
  output logic [31:0] v_z,
  output logic        v_clip,
  output logic        v_last
);

  state_t             state_q, state_d;
  logic [5:0]         n_q, n_d, idx_q, idx_d;
  logic [1:0]         comp_q, comp_d;
  logic [3:0]         wcnt_q, wcnt_d;
  logic [31:0]        x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [15:0] vx_q, vx_d, vy_q, vy_d;
  logic [31:0]        vz_q, vz_d;
  logic               clip_q, clip_d, last_q, last_d;
`ifdef CLIP_REJECT_EN
  logic               pend_q, pend_d;
  logic signed [15:0] hx_q, hx_d, hy_q, hy_d;
  logic [31:0]        hz_q, hz_d;
`endif

  logic signed [15:0] ix, iy, sx, sy;
  logic               ox, oy, cclip, is_last;
  logic signed [17:0] px, py;

  fp32_to_fixed #(.SCALE_SHIFT(SCALE_SHIFT)) u_cvt_x (.f(x_q), .val(ix), .ovf(ox));
  fp32_to_fixed #(.SCALE_SHIFT(SCALE_SHIFT)) u_cvt_y (.f(y_q), .val(iy), .ovf(oy));

  // Viewport mapping (y flipped) and clip classification of the captured vertex.
  always_comb begin
    px      = 18'(SCREEN_W / 2) + 18'(ix);
    py      = 18'(SCREEN_H / 2) - 18'(iy);
    sx      = sat16(px);
    sy      = sat16(py);
    cclip   = ox | oy | z_q[31] | (sx < 0) | (int'(sx) >= SCREEN_W) |
              (sy < 0) | (int'(sy) >= SCREEN_H);
    is_last = (idx_q == n_q - 6'd1);
  end

  assign result_addr = 32'(idx_q) * 32'd3 + 32'(comp_q);
  assign done        = (state_q == S_IDLE);
  assign v_valid     = (state_q == S_EMIT);
  assign v_x         = vx_q;
  assign v_y         = vy_q;
  assign v_z         = vz_q;
  assign v_clip      = clip_q;
  assign v_last      = last_q;

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    comp_d  = comp_q;
    wcnt_d  = wcnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    vz_d    = vz_q;
    clip_d  = clip_q;
    last_d  = last_q;
`ifdef CLIP_REJECT_EN
    pend_d  = pend_q;
    hx_d    = hx_q;
    hy_d    = hy_q;
    hz_d    = hz_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        n_d    = (count > 32'(MAX_VERTS)) ? 6'(MAX_VERTS) : count[5:0];
        idx_d  = '0;
        comp_d = '0;
`ifdef CLIP_REJECT_EN
        pend_d = 1'b0;
`endif
        if (n_d != 6'd0) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == 4'(RD_LAT - 1)) state_d = S_CAPTURE;
        else                          wcnt_d  = wcnt_q + 4'd1;
      end
      S_CAPTURE: begin
        case (comp_q)
          2'd0:    begin x_d = result_data; comp_d = 2'd1; state_d = S_ISSUE; end
          2'd1:    begin y_d = result_data; comp_d = 2'd2; state_d = S_ISSUE; end
          default: begin z_d = result_data; comp_d = 2'd0; state_d = S_CONVERT; end
        endcase
      end
`ifndef CLIP_REJECT_EN
      S_CONVERT: begin
        vx_d    = sx;
        vy_d    = sy;
        vz_d    = z_q;
        clip_d  = cclip;
        last_d  = is_last;
        state_d = S_EMIT;
      end
      S_EMIT: if (v_ready) begin
        if (last_q) state_d = S_IDLE;
        else begin
          idx_d   = idx_q + 6'd1;
          state_d = S_ISSUE;
        end
      end
`else
      // A surviving vertex waits in the output regs until the next survivor
      // (or batch end) is known; a later survivor parks in the h* regs.
      S_CONVERT: begin
        if (cclip) begin
          if (!is_last) begin
            idx_d   = idx_q + 6'd1;
            state_d = S_ISSUE;
          end else if (pend_q) begin
            last_d  = 1'b1;
            state_d = S_EMIT;
          end else begin
            state_d = S_IDLE;
          end
        end else if (pend_q) begin
          hx_d    = sx;
          hy_d    = sy;
          hz_d    = z_q;
          last_d  = 1'b0;
          state_d = S_EMIT;
        end else begin
          vx_d   = sx;
          vy_d   = sy;
          vz_d   = z_q;
          pend_d = 1'b1;
          if (is_last) begin
            last_d  = 1'b1;
            state_d = S_EMIT;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_EMIT: if (v_ready) begin
        if (last_q) begin
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          vx_d = hx_q;
          vy_d = hy_q;
          vz_d = hz_q;
          if (is_last) last_d = 1'b1;
          else begin
            idx_d   = idx_q + 6'd1;
            state_d = S_ISSUE;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      comp_q  <= '0;
      wcnt_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      vz_q    <= '0;
      clip_q  <= 1'b0;
      last_q  <= 1'b0;
`ifdef CLIP_REJECT_EN
      pend_q  <= 1'b0;
      hx_q    <= '0;
      hy_q    <= '0;
      hz_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      comp_q  <= comp_d;
      wcnt_q  <= wcnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vz_q    <= vz_d;
      clip_q  <= clip_d;
      last_q  <= last_d;
`ifdef CLIP_REJECT_EN
      pend_q  <= pend_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
      hz_q    <= hz_d;
`endif
    end
  end

endmodule
